// File: rtl/nfc_spi_master.sv
// SPI mode-0 initiator for the NFC reader: byte stream in, CE-framed SPI out, received bytes strobed back.
// Optional NFC_SPI_IRQ_EN adds a synchronised falling-edge pulse from the chip's active-low IRQ pin.
module nfc_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK_nfc,
  output logic       mosi_nfc,
  input  logic       miso_nfc,
  output logic       CE_nfc
`ifdef NFC_SPI_IRQ_EN
  ,
  input  logic       NFC_irq,
  output logic       irq_pulse
`endif
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    half_q;
  logic [7:0]    tx_sr_q;
  logic [7:0]    rx_sr_q;
  logic          last_q;
  logic          tick;

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      last_q   <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      SCK_nfc  <= 1'b0;
      mosi_nfc <= 1'b0;
      CE_nfc   <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE, NEXT: begin
          cnt_q    <= '0;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_sr_q  <= tx_data;
            last_q   <= tx_last;
            mosi_nfc <= tx_data[7];
            CE_nfc   <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          cnt_q <= cnt_q + 1'b1;
          // End of setup is also the first rising edge, so bit 7 is sampled here.
          if (tick) begin
            cnt_q   <= '0;
            SCK_nfc <= 1'b1;
            rx_sr_q <= {rx_sr_q[6:0], miso_nfc};
            half_q  <= 4'd1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (tick) begin
            cnt_q   <= '0;
            SCK_nfc <= ~SCK_nfc;
            half_q  <= half_q + 4'd1;
            if (!SCK_nfc) begin
              rx_sr_q <= {rx_sr_q[6:0], miso_nfc};
            end else begin
              tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
              mosi_nfc <= tx_sr_q[6];
            end
            // Sixteenth toggle is the eighth falling edge: byte complete.
            if (half_q == 4'd15) begin
              rx_data  <= rx_sr_q;
              rx_valid <= 1'b1;
              if (last_q) begin
                state_q <= HOLD;
              end else begin
                tx_ready <= 1'b1;
                state_q  <= NEXT;
              end
            end
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (tick) begin
            cnt_q   <= '0;
            CE_nfc  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          cnt_q <= cnt_q + 1'b1;
          if (tick) begin
            cnt_q    <= '0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NFC_SPI_IRQ_EN
  // [0],[1] synchronise; [2] is the previous synchronised level for edge detect.
  logic [2:0] irq_sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_sync_q <= 3'b111;
      irq_pulse  <= 1'b0;
    end else begin
      irq_sync_q <= {irq_sync_q[1:0], NFC_irq};
      irq_pulse  <= irq_sync_q[2] & ~irq_sync_q[1];
    end
  end
`endif

endmodule

// File: tb/tb_nfc_spi_master.sv
// Scoreboard bench for nfc_spi_master: CLK_DIV=4 instance with an SPI slave model, CLK_DIV=2 instance in loopback.
module tb_nfc_spi_master;
  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [7:0] tx_data, rx_data;
  logic       tx_last, tx_valid, tx_ready, rx_valid, busy, sck, mosi, miso, ce;
  logic [7:0] tx_data2, rx_data2;
  logic       tx_last2, tx_valid2, tx_ready2, rx_valid2, busy2, sck2, mosi2, miso2, ce2;
`ifdef NFC_SPI_IRQ_EN
  logic       irq_n, irq_pulse, irq_pulse2;
`endif

  nfc_spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .resetn(resetn),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK_nfc(sck), .mosi_nfc(mosi), .miso_nfc(miso), .CE_nfc(ce)
`ifdef NFC_SPI_IRQ_EN
    , .NFC_irq(irq_n), .irq_pulse(irq_pulse)
`endif
  );

  nfc_spi_master #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .resetn(resetn),
    .tx_data(tx_data2), .tx_last(tx_last2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
    .SCK_nfc(sck2), .mosi_nfc(mosi2), .miso_nfc(miso2), .CE_nfc(ce2)
`ifdef NFC_SPI_IRQ_EN
    , .NFC_irq(irq_n), .irq_pulse(irq_pulse2)
`endif
  );

  // Loopback: every byte sent must come back unchanged.
  assign miso2 = mosi2;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       last;
    int         t0;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];

  // SPI slave model for the CLK_DIV=4 instance: MSB-first, presents next bit after each SCK fall.
  logic [7:0] miso_byte = 8'h00;
  logic [2:0] idx       = 3'd0;
  logic [7:0] mosi_sr   = 8'h00;
  logic       prev_sck  = 1'b0;
  logic       prev_mosi = 1'b0;

  assign miso = miso_byte[~idx];

  always @(negedge clk) begin
    if (sck && prev_sck && (mosi !== prev_mosi)) check("mosi_changed_while_sck_high", mosi, prev_mosi);
    if (!prev_sck && sck && ce) check("sck_rise_with_ce_high", ce, 1'b0);
    if (ce) idx <= 3'd0;
    else if (prev_sck && !sck) idx <= idx + 3'd1;
    if (!prev_sck && sck) mosi_sr <= {mosi_sr[6:0], mosi};
    prev_sck  <= sck;
    prev_mosi <= mosi;
  end

  // Monitor for the CLK_DIV=4 instance.
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rx_valid", rx_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("mosi_byte", mosi_sr, e.tx);
          check("rx_valid_cycle", cyc, e.t0 + 1 + 16 * D);
          check("ce_low_at_rx", ce, 1'b0);
          check("busy_at_rx", busy, 1'b1);
          check("ready_with_rx", tx_ready, !e.last);
          if (e.last) begin
            n = 0;
            while (!ce && n < 4 * D) begin @(negedge clk); n++; end
            check("ce_rise_cycle", cyc, e.t0 + 1 + 17 * D);
            n = 0;
            while (!tx_ready && n < 4 * D) begin @(negedge clk); n++; end
            check("idle_ready_cycle", cyc, e.t0 + 1 + 18 * D);
            check("busy_idle", busy, 1'b0);
          end
        end
      end
    end
  end

  // Monitor for the CLK_DIV=2 loopback instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid2) begin
        if (q2.size() == 0) begin
          check("unexpected_rx_valid2", rx_valid2, 1'b0);
        end else begin
          e = q2.pop_front();
          check("rx_data2", rx_data2, e.rx);
          check("rx_valid2_cycle", cyc, e.t0 + 1 + 16 * D2);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] m, input bit track);
    int n;
    @(negedge clk);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      check("accept_timeout", tx_ready, 1'b1);
      tx_valid = 1'b0;
      return;
    end
    if (track) q.push_back('{d, m, l, cyc});
    @(posedge clk);
    #1;
    miso_byte = m;
    if (l) tx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_data2 = d; tx_last2 = 1'b1; tx_valid2 = 1'b1;
    n = 0;
    while (!tx_ready2 && n < 1000) begin @(negedge clk); n++; end
    if (!tx_ready2) begin
      check("accept2_timeout", tx_ready2, 1'b1);
      tx_valid2 = 1'b0;
      return;
    end
    q2.push_back('{d, d, 1'b1, cyc});
    @(posedge clk);
    #1;
    tx_valid2 = 1'b0;
  endtask

  initial begin
    int n, r, len;
    logic ps;
    resetn = 1'b0;
    tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
    tx_data2 = 8'h00; tx_last2 = 1'b0; tx_valid2 = 1'b0;
`ifdef NFC_SPI_IRQ_EN
    irq_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_ce", ce, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1'b1);

    // Single byte, known pattern.
    send(8'h8A, 1'b1, 8'h5C, 1'b1);

    // Three-byte frame with tx_valid held.
    send(8'h02, 1'b0, 8'($urandom), 1'b1);
    send(8'hFF, 1'b0, 8'($urandom), 1'b1);
    send(8'h00, 1'b1, 8'($urandom), 1'b1);

    // Stall in NEXT for 100 cycles.
    send(8'h3C, 1'b0, 8'($urandom), 1'b1);
    tx_valid = 1'b0;
    n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    check("next_ready_reached", tx_ready, 1'b1);
    repeat (100) begin
      @(negedge clk);
      check("stall_ce", ce, 1'b0);
      check("stall_sck", sck, 1'b0);
      check("stall_ready", tx_ready, 1'b1);
    end
    send(8'hC5, 1'b1, 8'($urandom), 1'b1);

    // Random frames with random inter-byte gaps.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          tx_valid = 1'b0;
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        send(8'($urandom), (b == len - 1), 8'($urandom), 1'b1);
      end
    end

    // Reset at the fifth SCK rise.
    send(8'hC3, 1'b1, 8'h3C, 1'b0);
    r = 0; n = 0; ps = sck;
    while (r < 5 && n < 500) begin
      @(negedge clk);
      if (sck && !ps) r++;
      ps = sck;
      n++;
    end
    check("fifth_rise_seen", r, 5);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_ce", ce, 1'b1);
    check("midrst_sck", sck, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_tx_ready", tx_ready, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", tx_ready, 1'b1);
    send(8'h5A, 1'b1, 8'hA5, 1'b1);
    send(8'($urandom), 1'b1, 8'($urandom), 1'b1);

    // CLK_DIV=2 loopback.
    for (int i = 0; i < 4; i++) send2(8'($urandom));

`ifdef NFC_SPI_IRQ_EN
    begin
      int c, pulses, pc, pulses2;
      @(negedge clk);
      irq_n = 1'b0;
      c = cyc; pulses = 0; pulses2 = 0; pc = -1;
      repeat (20) begin
        @(negedge clk);
        if (irq_pulse) begin pulses++; pc = cyc; end
        if (irq_pulse2) pulses2++;
      end
      check("irq_pulse_count", pulses, 1);
      check("irq_pulse_cycle", pc, c + 3);
      check("irq_pulse2_count", pulses2, 1);
      irq_n = 1'b1;
    end
`endif

    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    check("queues_drained", q.size() + q2.size(), 0);
    repeat (20 * D) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/nfc_spi_master.md
# nfc_spi_master

FPGA-side SPI initiator for the NFC reader chip. It lets on-board logic drive the NFC chip's SPI pins directly, rather than only forwarding the Raspberry Pi's SPI. The block serialises bytes from a valid/ready byte stream onto `mosi_nfc`/`SCK_nfc` and frames them with `CE_nfc`. It returns each byte shifted in on `miso_nfc` as a one-cycle strobe.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCK half-period; legal values ≥ 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `resetn` input 1: synchronous reset, active low.
- `tx_data` input 8: byte to send, MSB first.
- `tx_last` input 1: sampled with `tx_data`; 1 means release CE after this byte.
- `tx_valid` input 1: byte offered.
- `tx_ready` output 1: block can accept a byte; transfer occurs when `tx_valid && tx_ready`.
- `rx_data` output 8: byte received during the last completed byte slot.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is valid.
- `busy` output 1: high from the accept cycle until the block returns to IDLE.
- `SCK_nfc` output 1: SPI clock to the NFC chip, idle low.
- `mosi_nfc` output 1: SPI data to the NFC chip.
- `miso_nfc` input 1: SPI data from the NFC chip.
- `CE_nfc` output 1: chip enable, active low.
- `NFC_irq` input 1 / `irq_pulse` output 1: present only with `NFC_SPI_IRQ_EN` (see Configuration).

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
  - `mosi_nfc` changes only while `SCK_nfc` is low.
  - `miso_nfc` is sampled on the clk edge that drives `SCK_nfc` high.
- All outputs are registered. Reset values: `CE_nfc`=1, `SCK_nfc`=0, `mosi_nfc`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0x00, `busy`=0, `irq_pulse`=0.
- A divider counter of width `$clog2(CLK_DIV)` counts 0..CLK_DIV-1; its terminal count is a half-period tick. The counter is cleared on every state entry.
- States:
  - **IDLE**: `tx_ready`=1, `CE_nfc`=1. On accept, latch `tx_data`/`tx_last`, go to SETUP.
  - **SETUP** (CLK_DIV cycles): `CE_nfc`=0, `mosi_nfc`=bit 7, `SCK_nfc`=0. Then go to SHIFT.
  - **SHIFT** (16 half-periods): on each tick, toggle `SCK_nfc`.
    - Low→high: shift `miso_nfc` into the rx shift register.
    - High→low: present the next tx bit.
    - After the 8th falling edge, load `rx_data`, pulse `rx_valid`, and go to NEXT if `tx_last`=0, else to HOLD.
  - **NEXT**: `tx_ready`=1, `CE_nfc` held 0, `SCK_nfc`=0. Waits indefinitely. On accept, go to SETUP; CE stays low.
  - **HOLD** (CLK_DIV cycles): `CE_nfc`=0, then raise `CE_nfc`, go to GAP.
  - **GAP** (CLK_DIV cycles): `CE_nfc`=1 minimum deselect time, then go to IDLE.
- `tx_ready` is 0 in SETUP/SHIFT/HOLD/GAP; `tx_valid` is ignored there.
- `rx_data` holds its value until the next byte completes.
- Reset mid-transfer: on the next clk edge with `resetn`=0, all outputs take their reset values immediately (CE drops high mid-byte, allowed) and the state is IDLE.

## Timing
- Accept at cycle T0 (from IDLE or NEXT):
  - `CE_nfc`=0 and `mosi_nfc`=bit 7 at T0+1.
  - First SCK rise at T0+1+CLK_DIV.
  - 8th fall and `rx_valid` at T0+1+16·CLK_DIV.
- Last byte:
  - `CE_nfc`=1 at T0+1+17·CLK_DIV.
  - `tx_ready`=1 at T0+1+18·CLK_DIV.
- With CLK_DIV=4: `rx_valid` at T0+65, CE high at T0+69, `tx_ready` at T0+73.
- In NEXT, `tx_ready` rises in the same cycle as `rx_valid`. Back-to-back bytes are therefore gapless beyond SETUP.
- `tx_ready` first rises on the cycle after `resetn` is sampled high.

## Configuration
- `NFC_SPI_IRQ_EN` defined:
  - Adds `NFC_irq` (active low from the chip) and `irq_pulse`.
  - `NFC_irq` passes through a two-flop synchronizer with reset value 1.
  - A falling edge on the synchronized signal gives a one-cycle `irq_pulse`, 3 cycles after the input falls.
- Undefined: those ports and all related logic are absent.

## Test plan
- CLK_DIV=4, send 0x8A with `tx_last`=1, `miso_nfc` driven 0x5C in mode 0 → `mosi_nfc` bits 1,0,0,0,1,0,1,0 at rises; `rx_data`=0x5C with `rx_valid` at T0+65; CE high at T0+69; `tx_ready` at T0+73.
- Three-byte frame 0x02,0xFF,0x00 (last on the third), `tx_valid` held → CE stays low across all 24 SCK pulses; three `rx_valid` strobes.
- NEXT stall: withhold the second byte for 100 cycles → CE low, SCK low, `tx_ready`=1 throughout; transfer resumes with SETUP.
- `resetn` low at SCK rise 5 → next cycle `CE_nfc`=1, `SCK_nfc`=0, `busy`=0, no `rx_valid`; a fresh transfer afterward is correct.
- CLK_DIV=2 → `rx_valid` at T0+33.
- `NFC_SPI_IRQ_EN` defined: `NFC_irq` 1→0 → exactly one `irq_pulse` 3 cycles later; holding it low gives no further pulses.
